instr_fetch: RTL

- Instruction-fetch stage directly upstream of the ID-stage control decoder.
- Holds the fetch PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents {pc, instr, opcode} to ID with valid/ready.
- Accepts redirects (taken branch, jal, jalr target) from the execute path and flushes wrong-path instructions.

---
 rtl/instr_fetch_if.sv | 44 ++++
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory handshake, the redirect input and the ID-stage
// valid/ready channel seen by the instr_fetch stage.
// master = fetch stage side, slave = memory / execute / ID side.
// Optional: IFETCH_MISALIGN_TRAP_EN adds the fetch_misalign flag.
interface instr_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic [6:0]      id_opcode;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic            fetch_misalign;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        input  id_ready,
        output id_valid, id_pc, id_instr, id_opcode
`ifdef IFETCH_MISALIGN_TRAP_EN
        , output fetch_misalign
`endif
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        output id_ready,
        input  id_valid, id_pc, id_instr, id_opcode
`ifdef IFETCH_MISALIGN_TRAP_EN
        , input fetch_misalign
`endif
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds the fetch PC, issues word fetches over a req/ack
// handshake, buffers returned instructions in a small FIFO and presents
// {pc, instr, opcode} to the ID stage. Redirects flush wrong-path work; a request
// still outstanding at redirect time is drained (DROP) at its original address.
// Optional: define IFETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets
// (adds fetch_misalign and a TRAP state); otherwise redirect_pc[1:0] is ignored.
module instr_fetch #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int          PTR_W = $clog2(BUF_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

`ifdef IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, DROP, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] stale_addr;
    logic [XLEN-1:0] buf_pc    [BUF_DEPTH];
    logic [31:0]     buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic            req;
    logic            waiting;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] target;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;
    logic drain_to_trap;
    logic trap_next;

    assign target     = bus.redirect_pc;
    assign misaligned = |bus.redirect_pc[1:0];
    assign trap_next  = bus.redirect ? misaligned : drain_to_trap;
    assign bus.fetch_misalign = misalign_q;
`else
    assign target = bus.redirect_pc & ~XLEN'(3);
`endif

    assign req        = ((state == FETCH) && (count < CNT_W'(BUF_DEPTH))) || (state == DROP);
    assign waiting    = req && !bus.imem_ack;
    assign head_valid = (state == FETCH) && (count != '0);
    assign push       = (state == FETCH) && req && bus.imem_ack && !bus.redirect;
    assign pop        = head_valid && bus.id_ready && !bus.redirect;
    assign head_instr = head_valid ? buf_instr[rd_ptr] : NOP;

    assign bus.imem_req  = req;
    assign bus.imem_addr = (state == DROP) ? stale_addr : fpc;
    assign bus.id_valid  = head_valid;
    assign bus.id_pc     = head_valid ? buf_pc[rd_ptr] : '0;
    assign bus.id_instr  = head_instr;
    assign bus.id_opcode = head_instr[6:0];

    // Fetch control FSM: PC advance, redirect handling and draining of stale requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            stale_addr <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
            drain_to_trap <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (bus.redirect) begin
                        fpc <= target;
                        if (waiting) begin
                            stale_addr <= fpc;
                            state      <= DROP;
                        end
`ifdef IFETCH_MISALIGN_TRAP_EN
                        misalign_q    <= misaligned;
                        drain_to_trap <= misaligned && waiting;
                        if (misaligned && !waiting) begin
                            state <= TRAP;
                        end
`endif
                    end else if (push) begin
                        fpc <= fpc + XLEN'(4);
                    end
                end
                DROP: begin
                    if (bus.redirect) begin
                        fpc <= target;
`ifdef IFETCH_MISALIGN_TRAP_EN
                        misalign_q    <= misaligned;
                        drain_to_trap <= misaligned;
`endif
                    end
                    if (bus.imem_ack) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                        state <= trap_next ? TRAP : FETCH;
`else
                        state <= FETCH;
`endif
                    end
                end
`ifdef IFETCH_MISALIGN_TRAP_EN
                TRAP: begin
                    if (bus.redirect && !misaligned) begin
                        fpc        <= target;
                        misalign_q <= 1'b0;
                        state      <= FETCH;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO occupancy and pointers; a redirect empties the buffer and overrides any pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect && (state != IDLE)) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage: capture the returned instruction with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= fpc;
            buf_instr[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule
